// File: rtl/nn_cfg_pkg.sv
// Shared types and constants for the neuron configuration frame loader.
// Latency: n/a (package only).
// Backpressure: n/a. Optional macro CFG_CHECKSUM_EN adds the CHK state and trailer word.
package nn_cfg_pkg;

    localparam int WORD_W     = 32;
    localparam int CNT_W      = 16;

    // Header word field positions: {layer, neuron, count}
    localparam int LAYER_MSB  = 31;
    localparam int LAYER_LSB  = 24;
    localparam int NEURON_MSB = 23;
    localparam int NEURON_LSB = 16;
    localparam int COUNT_MSB  = 15;
    localparam int COUNT_LSB  = 0;

    // Fixed (non-weight) words per frame
    localparam int HDR_WORDS  = 1;
    localparam int BIAS_WORDS = 1;
`ifdef CFG_CHECKSUM_EN
    localparam int CHK_WORDS  = 1;
`else
    localparam int CHK_WORDS  = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WGT,
        BIAS,
`ifdef CFG_CHECKSUM_EN
        CHK,
`endif
        FIN
    } state_e;

    // A header is usable only if it targets an existing layer/neuron and
    // carries a non-empty, in-range weight count.
    function automatic logic hdr_ok(input logic [WORD_W-1:0] w,
                                    input int unsigned num_layers,
                                    input int unsigned max_neurons,
                                    input int unsigned max_weights);
        logic [31:0] layer;
        logic [31:0] neuron;
        logic [31:0] count;
        layer  = {24'd0, w[LAYER_MSB:LAYER_LSB]};
        neuron = {24'd0, w[NEURON_MSB:NEURON_LSB]};
        count  = {16'd0, w[COUNT_MSB:COUNT_LSB]};
        return (count != 32'd0) && (count <= max_weights) &&
               (layer < num_layers) && (neuron < max_neurons);
    endfunction

endpackage

// File: rtl/neuron_cfg_loader_if.sv
// Host word stream into the configuration loader (valid/ready).
// Latency: n/a (wires only).
// Backpressure: word transfers when s_valid & s_ready; master holds s_data while s_valid is high.
interface neuron_cfg_loader_if;
    import nn_cfg_pkg::*;

    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/neuron_cfg_loader.sv
// Parses host frames {header, count weights, bias[, checksum]} into per-word strobes
// and target layer/neuron select. Latency: every output updates one cycle after acceptance.
// Backpressure: s_ready drops for the single FIN cycle only. Optional macro: CFG_CHECKSUM_EN.
// Ports: clk/rst (sync, active-high); s_if slave stream; weight/bias strobes+values;
//        config_layer_num/config_neuron_num; busy, done and err status.
module neuron_cfg_loader
    import nn_cfg_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int MAX_NEURONS = 64,
    parameter int MAX_WEIGHTS = 784
) (
    input  logic               clk,
    input  logic               rst,
    neuron_cfg_loader_if.slave s_if,
    output logic               weightValid,
    output logic               biasValid,
    output logic [WORD_W-1:0]  weightValue,
    output logic [WORD_W-1:0]  biasValue,
    output logic [31:0]        config_layer_num,
    output logic [31:0]        config_neuron_num,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        layer_q, layer_d;
    logic [7:0]        neuron_q, neuron_d;
    logic              wvld_q, wvld_d;
    logic              bvld_q, bvld_d;
    logic [WORD_W-1:0] wval_q, wval_d;
    logic [WORD_W-1:0] bval_q, bval_d;
    logic              err_q, err_d;
`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;
`endif

    logic accept;
    assign accept = s_if.s_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        wval_d   = wval_q;
        bval_d   = bval_q;
        wvld_d   = 1'b0;
        bvld_d   = 1'b0;
        err_d    = 1'b0;
`ifdef CFG_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_ok(s_if.s_data, NUM_LAYERS, MAX_NEURONS, MAX_WEIGHTS)) begin
                        state_d  = WGT;
                        layer_d  = s_if.s_data[LAYER_MSB:LAYER_LSB];
                        neuron_d = s_if.s_data[NEURON_MSB:NEURON_LSB];
                        cnt_d    = s_if.s_data[COUNT_MSB:COUNT_LSB];
`ifdef CFG_CHECKSUM_EN
                        csum_d   = '0;
`endif
                    end else begin
                        // Bad header: flag it and keep every output as it was.
                        err_d = 1'b1;
                    end
                end
            end
            WGT: begin
                if (accept) begin
                    wvld_d = 1'b1;
                    wval_d = s_if.s_data;
                    cnt_d  = cnt_q - 1'b1;
`ifdef CFG_CHECKSUM_EN
                    csum_d = csum_q ^ s_if.s_data;
`endif
                    if (cnt_q == 16'd1) begin
                        state_d = BIAS;
                    end
                end
            end
            BIAS: begin
                if (accept) begin
                    bvld_d = 1'b1;
                    bval_d = s_if.s_data;
`ifdef CFG_CHECKSUM_EN
                    csum_d  = csum_q ^ s_if.s_data;
                    state_d = CHK;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (s_if.s_data == csum_q) begin
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered so s_ready is a clean flop output; low only while in FIN.
        ready_d = (state_d != FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            layer_q  <= '0;
            neuron_q <= '0;
            wvld_q   <= 1'b0;
            bvld_q   <= 1'b0;
            wval_q   <= '0;
            bval_q   <= '0;
            err_q    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            wvld_q   <= wvld_d;
            bvld_q   <= bvld_d;
            wval_q   <= wval_d;
            bval_q   <= bval_d;
            err_q    <= err_d;
`ifdef CFG_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign s_if.s_ready      = ready_q;
    assign weightValid       = wvld_q;
    assign biasValid         = bvld_q;
    assign weightValue       = wval_q;
    assign biasValue         = bval_q;
    assign config_layer_num  = {24'd0, layer_q};
    assign config_neuron_num = {24'd0, neuron_q};
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == FIN);
    assign err               = err_q;

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Scoreboard bench for neuron_cfg_loader: weight/bias expectations queued as driven,
// popped when the strobes appear; frame-level counts checked after each frame.
// Build with +define+CFG_CHECKSUM_EN to exercise the checksum trailer.
module tb_neuron_cfg_loader;
    import nn_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_cfg_loader_if s_if();

    logic        weightValid, biasValid, busy, done, err;
    logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;

    neuron_cfg_loader #(.NUM_LAYERS(4), .MAX_NEURONS(64), .MAX_WEIGHTS(784)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_if              (s_if.slave),
        .weightValid       (weightValid),
        .biasValid         (biasValid),
        .weightValue       (weightValue),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq[$];
    logic [31:0] bq[$];
    logic [31:0] wbuf [0:1023];
    int done_cnt = 0, err_cnt = 0, rdy_low_cnt = 0, wv_cnt = 0, bv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (weightValid || biasValid)
            check("wv_bv_exclusive", {31'd0, weightValid & biasValid}, 32'd0);
        if (weightValid) begin
            wv_cnt++;
            if (wq.size() == 0) check("wgt_unexpected", 32'(wq.size()), 32'd1);
            else                check("wgt_value", weightValue, wq.pop_front());
        end
        if (biasValid) begin
            bv_cnt++;
            if (bq.size() == 0) check("bias_unexpected", 32'(bq.size()), 32'd1);
            else                check("bias_value", biasValue, bq.pop_front());
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (busy && !s_if.s_ready) rdy_low_cnt++;
    end

    // Offer one word after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send(input logic [31:0] w, input int gap);
        int to;
        repeat (gap) begin
            s_if.s_valid = 1'b0;
            @(negedge clk);
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = w;
        to = 0;
        while (!s_if.s_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) check("send_timeout", 32'(to), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] l, input logic [7:0] n, input logic [15:0] cnt,
                             input logic [31:0] bias_w, input int maxgap, input bit good_chk);
        int d0, e0, r0, w0, b0;
        logic [31:0] x;
        d0 = done_cnt; e0 = err_cnt; r0 = rdy_low_cnt; w0 = wv_cnt; b0 = bv_cnt;
        x = '0;
        send({l, n, cnt}, 0);
        for (int i = 0; i < int'(cnt); i++) begin
            wq.push_back(wbuf[i]);
            x ^= wbuf[i];
            send(wbuf[i], $urandom_range(0, maxgap));
        end
        bq.push_back(bias_w);
        x ^= bias_w;
        send(bias_w, $urandom_range(0, maxgap));
`ifdef CFG_CHECKSUM_EN
        send(good_chk ? x : (x ^ 32'h1), $urandom_range(0, maxgap));
`endif
        s_if.s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("cfg_layer",  config_layer_num,  {24'd0, l});
        check("cfg_neuron", config_neuron_num, {24'd0, n});
        check("done_pulses", 32'(done_cnt - d0), good_chk ? 32'd1 : 32'd0);
        check("err_pulses",  32'(err_cnt - e0),  good_chk ? 32'd0 : 32'd1);
        check("rdy_low_cycles", 32'(rdy_low_cnt - r0), good_chk ? 32'd1 : 32'd0);
        check("wv_pulses", 32'(wv_cnt - w0), {16'd0, cnt});
        check("bv_pulses", 32'(bv_cnt - b0), 32'd1);
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("bq_drained", 32'(bq.size()), 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("ready_idle", {31'd0, s_if.s_ready}, 32'd1);
    endtask

    task automatic bad_header(input string tag, input logic [31:0] hdr);
        int w0, b0, d0;
        logic [31:0] l0, n0;
        w0 = wv_cnt; b0 = bv_cnt; d0 = done_cnt;
        l0 = config_layer_num; n0 = config_neuron_num;
        send(hdr, 0);
        s_if.s_valid = 1'b0;
        check({tag, "_err_hi"}, {31'd0, err}, 32'd1);
        check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_err_lo"}, {31'd0, err}, 32'd0);
        check({tag, "_busy0b"}, {31'd0, busy}, 32'd0);
        check({tag, "_layer_kept"}, config_layer_num, l0);
        check({tag, "_neuron_kept"}, config_neuron_num, n0);
        check({tag, "_no_strobes"}, 32'((wv_cnt - w0) + (bv_cnt - b0) + (done_cnt - d0)), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wv"},   {31'd0, weightValid}, 32'd0);
        check({tag, "_bv"},   {31'd0, biasValid}, 32'd0);
        check({tag, "_wval"}, weightValue, 32'd0);
        check({tag, "_bval"}, biasValue, 32'd0);
        check({tag, "_layer"}, config_layer_num, 32'd0);
        check({tag, "_neuron"}, config_neuron_num, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, err}, 32'd0);
        check({tag, "_rdy"},  {31'd0, s_if.s_ready}, 32'd0);
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, s_if.s_ready}, 32'd1);

        // Basic back-to-back frame.
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
        run_frame(8'd2, 8'd5, 16'd3, 32'h44, 0, 1'b1);

        // Rejected headers.
        bad_header("cnt0",   {8'd1, 8'd1, 16'd0});
        bad_header("layer4", {8'd4, 8'd0, 16'd1});
        bad_header("nrn64",  {8'd0, 8'd64, 16'd1});
        bad_header("cnt785", {8'd0, 8'd0, 16'd785});

        // Maximum-size frame with random s_valid gaps.
        for (int i = 0; i < 784; i++) wbuf[i] = $urandom;
        run_frame(8'd3, 8'd63, 16'd784, $urandom, 5, 1'b1);

        // Reset mid-frame after two of three weights.
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1;
        send({8'd0, 8'd3, 16'd3}, 0);
        for (int i = 0; i < 2; i++) begin
            wq.push_back(wbuf[i]);
            send(wbuf[i], 0);
        end
        rst = 1'b1;
        s_if.s_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        check("midrst_wq", 32'(wq.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, s_if.s_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        wbuf[0] = 32'hC0FFEE01; wbuf[1] = 32'hC0FFEE02;
        run_frame(8'd1, 8'd0, 16'd2, 32'hB1A5, 2, 1'b1);

`ifdef CFG_CHECKSUM_EN
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        run_frame(8'd0, 8'd1, 16'd2, 32'h4, 0, 1'b1);
        run_frame(8'd0, 8'd2, 16'd2, 32'h4, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
